// File: rtl/onehot_scan_encoder_pkg.sv
// -----------------------------------------------------------------------------
// onehot_scan_encoder_pkg
//   Shared definitions for the one-hot scan encoder: line/code widths, the
//   controller state type and a population-count helper.
// -----------------------------------------------------------------------------
package onehot_scan_encoder_pkg;

    localparam int N_LINES = 8;                    // request lines
    localparam int CODE_W  = 3;                    // clog2(N_LINES)
    localparam int CNT_W   = 4;                    // holds 0..N_LINES

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Number of set lines in an 8-bit request vector.
    function automatic logic [CNT_W-1:0] popcount8(input logic [7:0] v);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/onehot_scan_encoder_if.sv
// -----------------------------------------------------------------------------
// onehot_scan_encoder_if
//   Valid/ready code stream between the encoder (master) and a consumer
//   (slave).
//     code       : encoded line index {w0,w1,w2}, w0 = MSB
//     code_valid : code is presented
//     code_ready : consumer accepts the presented code
// -----------------------------------------------------------------------------
interface onehot_scan_encoder_if;
    import onehot_scan_encoder_pkg::*;

    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;

    modport master (output code, output code_valid, input code_ready);
    modport slave  (input code, input code_valid, output code_ready);

endinterface

// File: rtl/onehot_scan_encoder_prio_enc8.sv
// -----------------------------------------------------------------------------
// prio_enc8
//   Combinational 8-to-3 priority encoder with selectable direction.
//     lsb_first : 1 = lowest set index wins, 0 = highest set index wins
//     vec       : input lines
//     code      : index of the winning line (0 when vec is all-zero)
//     any       : at least one line is set
// -----------------------------------------------------------------------------
module prio_enc8
    import onehot_scan_encoder_pkg::*;
(
    input  logic               lsb_first,
    input  logic [N_LINES-1:0] vec,
    output logic [CODE_W-1:0]  code,
    output logic               any
);

    always_comb begin
        // NOTE: every output gets a value before any branch so no path can
        // leave it unassigned and infer a latch.
        code = '0;
        any  = |vec;
        // Later hits overwrite earlier ones, so the scan runs from the
        // lowest-priority end toward the winner.
        if (lsb_first) begin
            for (int i = N_LINES - 1; i >= 0; i--) begin
                if (vec[i]) code = CODE_W'(i);
            end
        end else begin
            for (int i = 0; i < N_LINES; i++) begin
                if (vec[i]) code = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_scan_encoder.sv
// -----------------------------------------------------------------------------
// onehot_scan_encoder
//   Captures an 8-line request vector on a start strobe and emits the 3-bit
//   index of every set line, one per valid/ready handshake, in priority
//   order; then pulses done. An all-zero capture pulses none instead.
//   Ports:
//     clk      : rising-edge clock
//     rst      : synchronous reset, active-high
//     en       : block enable; start is ignored while low
//     start    : capture strobe, sampled in IDLE only
//     y        : request lines, y[0] maps to code 000
//     cs       : code stream (code / code_valid / code_ready), master side
//     busy     : emission in progress
//     done     : one-cycle pulse after the last code is accepted
//     none     : one-cycle pulse when the captured vector was all-zero
//     pending  : number of set lines still to emit
// -----------------------------------------------------------------------------
module onehot_scan_encoder
    import onehot_scan_encoder_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1      // 1: y[0] emitted first
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    input  logic [N_LINES-1:0]           y,
    onehot_scan_encoder_if.master        cs,
    output logic                         busy,
    output logic                         done,
    output logic                         none,
    output logic [CNT_W-1:0]             pending
);

    state_t             state;
    logic [N_LINES-1:0] mask;           // lines not yet emitted

    logic [CODE_W-1:0]  cur_code;
    logic               cur_any_unused;
    logic [N_LINES-1:0] rest_mask;
    logic               rest_any;
    logic [CODE_W-1:0]  rest_code_unused;

    // Current code: mask is zero outside EMIT, so code reads 000 there.
    prio_enc8 u_cur (
        .lsb_first (LSB_FIRST),
        .vec       (mask),
        .code      (cur_code),
        .any       (cur_any_unused)
    );

    // Mask after the current line is accepted; empty means it was the last.
    assign rest_mask = mask & ~(N_LINES'(1) << cur_code);

    prio_enc8 u_rest (
        .lsb_first (LSB_FIRST),
        .vec       (rest_mask),
        .code      (rest_code_unused),
        .any       (rest_any)
    );

    assign busy          = (state == EMIT);
    assign cs.code_valid = busy;
    assign cs.code       = cur_code;

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mask    <= '0;
            pending <= '0;
            done    <= 1'b0;
            none    <= 1'b0;
        end else begin
            done <= 1'b0;
            none <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && start) begin
                        if (|y) begin
                            mask    <= y;
                            pending <= popcount8(y);
                            state   <= EMIT;
                        end else begin
                            none <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // start/y/en are deliberately ignored here.
                    if (cs.code_ready) begin
                        mask    <= rest_mask;
                        pending <= pending - CNT_W'(1);
                        if (!rest_any) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_onehot_scan_encoder
//   Self-checking bench: a table of hand-derived vectors, hand-written
//   multi-cycle sequences and a randomized phase checked against a
//   queue-based reference model.
// -----------------------------------------------------------------------------
module tb_onehot_scan_encoder;
    import onehot_scan_encoder_pkg::*;

    localparam bit LSB_FIRST = 1'b1;

    logic             clk;
    logic             rst;
    logic             en;
    logic             start;
    logic [7:0]       y;
    logic             busy;
    logic             done;
    logic             none;
    logic [3:0]       pending;

    onehot_scan_encoder_if bus ();

    onehot_scan_encoder #(.LSB_FIRST(LSB_FIRST)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (start),
        .y       (y),
        .cs      (bus),
        .busy    (busy),
        .done    (done),
        .none    (none),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: the indices still to be emitted, in emission order.
    int m_q[$];
    bit m_done;
    bit m_none;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit s,
                              input logic [7:0] yv, input bit rdy);
        m_done = 1'b0;
        m_none = 1'b0;
        if (r) begin
            m_q.delete();
        end else if (m_q.size() > 0) begin
            if (rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (e && s) begin
            if (yv == 8'h00) begin
                m_none = 1'b1;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    int idx;
                    idx = LSB_FIRST ? k : 7 - k;
                    if (yv[idx]) m_q.push_back(idx);
                end
            end
        end
    endtask

    // Apply inputs for one clock edge; return #1 after the edge.
    task automatic cycle(input bit r, input bit e, input bit s,
                         input logic [7:0] yv, input bit rdy);
        rst            = r;
        en             = e;
        start          = s;
        y              = yv;
        bus.code_ready = rdy;
        @(posedge clk);
        model_step(r, e, s, yv, rdy);
        #1;
    endtask

    task automatic check_model(input string tag);
        int exp_code;
        exp_code = (m_q.size() > 0) ? m_q[0] : 0;
        check({tag, ".code"},    32'(bus.code),       32'(exp_code));
        check({tag, ".valid"},   32'(bus.code_valid), 32'(m_q.size() > 0));
        check({tag, ".busy"},    32'(busy),           32'(m_q.size() > 0));
        check({tag, ".pending"}, 32'(pending),        32'(m_q.size()));
        check({tag, ".done"},    32'(done),           32'(m_done));
        check({tag, ".none"},    32'(none),           32'(m_none));
        check({tag, ".excl"},    32'(done & none),    32'(0));
    endtask

    typedef struct {
        int r, e, s, y, rdy;
        int code, vld, bsy, dn, nn, pend;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // inputs: r e s y rdy | expected: code vld busy done none pending
        // single line 0000_0100
        tbl[0]  = '{0, 1, 1, 'h04, 1,   2, 1, 1, 0, 0, 1};
        tbl[1]  = '{0, 0, 0, 'h00, 1,   0, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 'h00, 1,   0, 0, 0, 0, 0, 0};
        // all-zero capture
        tbl[3]  = '{0, 1, 1, 'h00, 1,   0, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 'h00, 1,   0, 0, 0, 0, 0, 0};
        // disabled start
        tbl[5]  = '{0, 0, 1, 'h01, 1,   0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 'h00, 1,   0, 0, 0, 0, 0, 0};
        // backpressure on 1010_0010 (en dropped mid-emit)
        tbl[7]  = '{0, 1, 1, 'hA2, 0,   1, 1, 1, 0, 0, 3};
        tbl[8]  = '{0, 0, 0, 'h00, 0,   1, 1, 1, 0, 0, 3};
        tbl[9]  = '{0, 0, 0, 'h00, 0,   1, 1, 1, 0, 0, 3};
        tbl[10] = '{0, 0, 0, 'h00, 0,   1, 1, 1, 0, 0, 3};
        tbl[11] = '{0, 0, 0, 'h00, 1,   5, 1, 1, 0, 0, 2};
        tbl[12] = '{0, 0, 0, 'h00, 0,   5, 1, 1, 0, 0, 2};
        tbl[13] = '{0, 0, 0, 'h00, 1,   7, 1, 1, 0, 0, 1};
        tbl[14] = '{0, 0, 0, 'h00, 1,   0, 0, 0, 1, 0, 0};
        // back-to-back: start in the done cycle
        tbl[15] = '{0, 1, 1, 'h01, 1,   0, 1, 1, 0, 0, 1};
        tbl[16] = '{0, 1, 0, 'h00, 1,   0, 0, 0, 1, 0, 0};
        tbl[17] = '{0, 1, 1, 'h80, 0,   7, 1, 1, 0, 0, 1};
        tbl[18] = '{0, 0, 0, 'h00, 1,   0, 0, 0, 1, 0, 0};

        rst = 1'b1; en = 1'b0; start = 1'b0; y = 8'h00; bus.code_ready = 1'b0;

        // ---- reset state ----
        cycle(1, 0, 0, 8'h00, 0);
        cycle(1, 1, 1, 8'hFF, 1);
        check("rst.code",    32'(bus.code),       32'(0));
        check("rst.valid",   32'(bus.code_valid), 32'(0));
        check("rst.busy",    32'(busy),           32'(0));
        check("rst.done",    32'(done),           32'(0));
        check("rst.none",    32'(none),           32'(0));
        check("rst.pending", 32'(pending),        32'(0));

        // ---- table-driven vectors ----
        for (int i = 0; i < 19; i++) begin
            vec_t t;
            string tag;
            t = tbl[i];
            cycle(1'(t.r), 1'(t.e), 1'(t.s), 8'(t.y), 1'(t.rdy));
            tag = $sformatf("tbl%0d", i);
            check({tag, ".code"},    32'(bus.code),       32'(t.code));
            check({tag, ".valid"},   32'(bus.code_valid), 32'(t.vld));
            check({tag, ".busy"},    32'(busy),           32'(t.bsy));
            check({tag, ".done"},    32'(done),           32'(t.dn));
            check({tag, ".none"},    32'(none),           32'(t.nn));
            check({tag, ".pending"}, 32'(pending),        32'(t.pend));
        end
        cycle(0, 0, 0, 8'h00, 0);

        // ---- full vector at full rate ----
        cycle(0, 1, 1, 8'hFF, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("full.code%0d", i),    32'(bus.code),       32'(i));
            check($sformatf("full.pending%0d", i), 32'(pending),        32'(8 - i));
            check($sformatf("full.valid%0d", i),   32'(bus.code_valid), 32'(1));
            cycle(0, 0, 0, 8'h00, 1);
        end
        check("full.done", 32'(done), 32'(1));
        check("full.busy", 32'(busy), 32'(0));
        cycle(0, 0, 0, 8'h00, 0);

        // ---- start ignored while busy ----
        cycle(0, 1, 1, 8'h06, 0);
        cycle(0, 1, 1, 8'h80, 0);
        check("ign.code",    32'(bus.code), 32'(1));
        check("ign.pending", 32'(pending),  32'(2));
        cycle(0, 1, 1, 8'h80, 1);
        check("ign.code2",   32'(bus.code), 32'(2));
        check("ign.pending2", 32'(pending), 32'(1));
        cycle(0, 0, 0, 8'h00, 1);
        check("ign.done",    32'(done),     32'(1));
        cycle(0, 0, 0, 8'h00, 0);
        check("ign.idle",    32'(busy),     32'(0));

        // ---- reset mid-operation ----
        cycle(0, 1, 1, 8'hFF, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 1);
        check("rmid.code", 32'(bus.code), 32'(3));
        cycle(1, 0, 0, 8'h00, 1);
        check("rmid.busy",    32'(busy),           32'(0));
        check("rmid.valid",   32'(bus.code_valid), 32'(0));
        check("rmid.pending", 32'(pending),        32'(0));
        check("rmid.done",    32'(done),           32'(0));
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 8'h00, 1);
            check($sformatf("rmid.nodone%0d", i), 32'(done), 32'(0));
        end

        // ---- randomized phase against the reference model ----
        check_model("sync");
        for (int i = 0; i < 3000; i++) begin
            bit r, e, s, rdy;
            logic [7:0] yv;
            r   = ($urandom_range(0, 199) == 0);
            e   = ($urandom_range(0, 3) != 0);
            s   = ($urandom_range(0, 9) < 3);
            rdy = ($urandom_range(0, 9) < 6);
            yv  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            cycle(r, e, s, yv, rdy);
            check_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/onehot_scan_encoder.md
Name: onehot_scan_encoder

Overview:
- Sequential encoder, the inverse of the team's 3-to-8 enable decoder.
- Captures an 8-line request vector (y0..y7) on a start strobe.
- Emits the 3-bit code {w0,w1,w2} of each set line, one per valid/ready handshake, in priority order, then signals done.
- Sits between line-level request sources and any consumer that re-decodes codes with the existing decoder.

Parameters:
- N_LINES, 8, number of request lines; fixed at 8 for this release.
- CODE_W, 3, code width; must equal clog2(N_LINES).
- LSB_FIRST, 1, 1 = lowest index emitted first (y0 highest priority); 0 = highest index first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  block enable; start is ignored when low
- start  input  1  capture strobe, sampled in IDLE only
- y  input  8  request lines; y[0] corresponds to code 000
- code  output  3  encoded index {w0,w1,w2}, MSB = w0; valid only when code_valid=1
- code_valid  output  1  code is presented
- code_ready  input  1  consumer accepts code
- busy  output  1  high in EMIT state
- done  output  1  one-cycle pulse after last code accepted
- none  output  1  one-cycle pulse when captured vector was all-zero
- pending  output  4  number of set bits still to emit (0..8)

Behaviour:
- Reset (clk edge with rst=1) forces:
  - state=IDLE, internal mask=0
  - code=000, code_valid=0, busy=0, done=0, none=0, pending=0
- Reset mid-EMIT discards the remaining mask; no done pulse is generated.
- State IDLE:
  - If en=1 and start=1 at an edge and y!=0: mask<=y, pending<=popcount(y), state<=EMIT.
  - If en=1, start=1 and y==0: none=1 for the next cycle only, stay IDLE.
  - Otherwise hold.
- State EMIT:
  - code is combinational from the registered mask: priority index per LSB_FIRST.
  - code_valid=1 and busy=1 throughout.
  - First code appears the cycle after the capture edge (latency 1).
  - On an edge with code_valid=1 and code_ready=1: clear that bit in mask, pending<=pending-1.
  - If the cleared bit was the last one: state<=IDLE, done=1 the next cycle (same cycle code_valid drops).
  - With code_ready=0: code and code_valid must hold stable; mask is unchanged.
- start/y/en while busy:
  - Ignored; there is no re-capture and no queuing.
  - en dropping mid-EMIT does not abort emission.
- Back-to-back:
  - start may be asserted in the same cycle done is high (state is IDLE); capture occurs normally.
- Throughput: one code per cycle with code_ready held at 1.
  - Total EMIT cycles equal popcount(y) when code_ready=1 throughout.
- done and none are never high together.
- Outside EMIT: code=000 and pending=0.

Decomposition:
- Shared package holds:
  - localparams N_LINES=8, CODE_W=3
  - state enum {IDLE, EMIT}
  - function popcount8
- Sub-module prio_enc8:
  - Combinational 8-to-3 priority encoder with a direction input (LSB_FIRST).
  - Outputs code and any.
  - Reused for the code output and for the last-bit check (mask with current bit cleared, any==0).

Test Plan:
- Reset mid-operation: capture y=8'b1111_1111, accept 3 codes, assert rst -> next cycle busy=0, code_valid=0, pending=0, done never pulses.
- Single line: en=1, start, y=8'b0000_0100 with code_ready=1 -> the cycle after capture: code=010, code_valid=1, pending=1; next cycle: done=1, busy=0.
- Full vector at full rate: y=8'hFF, LSB_FIRST=1, code_ready=1 -> codes 000,001,...,111 on 8 consecutive cycles, pending 8→1, then done.
- Backpressure: y=8'b1010_0010, code_ready low for 3 cycles -> code=001 stable for those cycles; then codes 001,101,111 as ready toggles 1/0/1/1; done after the third accept.
- Zero and disabled:
  - start with y=0 -> none=1 for exactly one cycle, busy stays 0.
  - start with en=0, y=8'h01 -> no response.
- Ignored start plus back-to-back: during EMIT, pulse start with y=8'h80 -> ignored, original sequence intact; start in the done cycle with y=8'h80 -> capture occurs, code=111 in the next cycle.
